// File: rtl/eth_udp_pkg.sv
// Shared constants and types for the Ethernet/UDP video receive path.
// Holds header field values, header lengths, the one-hot state encoding
// and small byte-select helpers used by the receive parser.
package eth_udp_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hd5;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;

    localparam logic [4:0]  ETH_HEAD_LEN  = 5'd14;
    localparam logic [4:0]  IP_HEAD_LEN   = 5'd20;
    localparam logic [4:0]  UDP_HEAD_LEN  = 5'd8;

    // One-hot parser states, same encoding style as the TX block.
    typedef enum logic [6:0] {
        StIdle     = 7'b000_0001,
        StPreamble = 7'b000_0010,
        StEthHead  = 7'b000_0100,
        StIpHead   = 7'b000_1000,
        StUdpHead  = 7'b001_0000,
        StRxData   = 7'b010_0000,
        StRxEnd    = 7'b100_0000
    } state_e;

    // Byte idx (0 = most significant) of a 48-bit MAC address.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [47:0] sh;
        sh = mac << {idx, 3'b000};
        return sh[47:40];
    endfunction

    // Byte idx (0 = most significant) of a 32-bit IPv4 address.
    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
        logic [31:0] sh;
        sh = ip << {idx, 3'b000};
        return sh[31:24];
    endfunction

endpackage

// File: rtl/video_trans_eth_udp_rx.sv
// GMII Ethernet/IPv4/UDP receive parser.
// Strips preamble/SFD and the Ethernet, IPv4 and UDP headers, filters on the
// board MAC (or broadcast) and board IP, and packs UDP payload bytes into
// 32-bit words, first byte in [31:24].
// Ports:
//   clk, rst          GMII RX clock, synchronous active-high reset
//   gmii_rx_dv/rxd    GMII receive data valid and byte
//   rec_en/rec_data   one-cycle word strobe and payload word
//   rec_pkt_done      one-cycle pulse when a packet completes correctly
//   rec_byte_num      payload byte count of the last completed packet
//   src_mac/src_ip    source addresses of the last completed packet
//   rx_err            one-cycle pulse when the current frame is dropped
module video_trans_eth_udp_rx
    import eth_udp_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rec_en,
    output logic [31:0] rec_data,
    output logic        rec_pkt_done,
    output logic [15:0] rec_byte_num,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic        rx_err
);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [15:0] data_cnt_q, data_cnt_d;
    logic [15:0] data_num_q, data_num_d;
    logic [15:0] udp_len_q, udp_len_d;
    logic [1:0]  mac_hit_q, mac_hit_d;  // {broadcast still possible, board MAC still possible}
    logic [47:0] mac_sh_q, mac_sh_d;
    logic [31:0] ip_sh_q, ip_sh_d;
    logic [31:0] word_q, word_d;

    logic        rec_en_d, rec_pkt_done_d, rx_err_d;
    logic [31:0] rec_data_d;
    logic [15:0] rec_byte_num_d;
    logic [47:0] src_mac_d;
    logic [31:0] src_ip_d;

    logic        bad;
    logic        active;
    logic [1:0]  hit;
    logic [1:0]  pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            data_cnt_q   <= '0;
            data_num_q   <= '0;
            udp_len_q    <= '0;
            mac_hit_q    <= '0;
            mac_sh_q     <= '0;
            ip_sh_q      <= '0;
            word_q       <= '0;
            rec_en       <= 1'b0;
            rec_data     <= '0;
            rec_pkt_done <= 1'b0;
            rec_byte_num <= '0;
            src_mac      <= '0;
            src_ip       <= '0;
            rx_err       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_cnt_q   <= data_cnt_d;
            data_num_q   <= data_num_d;
            udp_len_q    <= udp_len_d;
            mac_hit_q    <= mac_hit_d;
            mac_sh_q     <= mac_sh_d;
            ip_sh_q      <= ip_sh_d;
            word_q       <= word_d;
            rec_en       <= rec_en_d;
            rec_data     <= rec_data_d;
            rec_pkt_done <= rec_pkt_done_d;
            rec_byte_num <= rec_byte_num_d;
            src_mac      <= src_mac_d;
            src_ip       <= src_ip_d;
            rx_err       <= rx_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        data_cnt_d     = data_cnt_q;
        data_num_d     = data_num_q;
        udp_len_d      = udp_len_q;
        mac_hit_d      = mac_hit_q;
        mac_sh_d       = mac_sh_q;
        ip_sh_d        = ip_sh_q;
        word_d         = word_q;
        rec_en_d       = 1'b0;
        rec_data_d     = rec_data;
        rec_pkt_done_d = 1'b0;
        rec_byte_num_d = rec_byte_num;
        src_mac_d      = src_mac;
        src_ip_d       = src_ip;
        rx_err_d       = 1'b0;
        bad            = 1'b0;
        hit            = 2'b00;
        pos            = data_cnt_q[1:0];
        active         = !(state_q == StIdle || state_q == StRxEnd);

        unique case (state_q)
            StIdle: begin
                if (gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE) begin
                    state_d = StPreamble;
                    cnt_d   = 5'd1;
                end
            end
            StPreamble: begin
                if (gmii_rx_dv) begin
                    if (cnt_q < 5'd7) begin
                        bad   = gmii_rxd != PREAMBLE_BYTE;
                        cnt_d = cnt_q + 5'd1;
                    end else begin
                        bad     = gmii_rxd != SFD_BYTE;
                        state_d = StEthHead;
                        cnt_d   = 5'd0;
                    end
                end
            end
            StEthHead: begin
                if (gmii_rx_dv) begin
                    if (cnt_q < 5'd6) begin
                        // Destination must match board MAC or broadcast over all six bytes.
                        hit       = (cnt_q == 5'd0) ? 2'b11 : mac_hit_q;
                        hit[0]    = hit[0] && (gmii_rxd == mac_byte(BOARD_MAC, cnt_q[2:0]));
                        hit[1]    = hit[1] && (gmii_rxd == 8'hff);
                        mac_hit_d = hit;
                        bad       = hit == 2'b00;
                    end else if (cnt_q < 5'd12) begin
                        mac_sh_d = {mac_sh_q[39:0], gmii_rxd};
                    end else if (cnt_q == 5'd12) begin
                        bad = gmii_rxd != ETH_TYPE_IPV4[15:8];
                    end else begin
                        bad = gmii_rxd != ETH_TYPE_IPV4[7:0];
                    end
                    if (cnt_q == ETH_HEAD_LEN - 5'd1) begin
                        state_d = StIpHead;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            StIpHead: begin
                if (gmii_rx_dv) begin
                    if (cnt_q == 5'd0) begin
                        bad = gmii_rxd != IP_VER_IHL;
                    end else if (cnt_q == 5'd9) begin
                        bad = gmii_rxd != IP_PROTO_UDP;
                    end else if (cnt_q >= 5'd12 && cnt_q < 5'd16) begin
                        ip_sh_d = {ip_sh_q[23:0], gmii_rxd};
                    end else if (cnt_q >= 5'd16) begin
                        bad = gmii_rxd != ip_byte(BOARD_IP, cnt_q[1:0]);
                    end
                    if (cnt_q == IP_HEAD_LEN - 5'd1) begin
                        state_d = StUdpHead;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            StUdpHead: begin
                if (gmii_rx_dv) begin
                    if (cnt_q == 5'd4 || cnt_q == 5'd5) begin
                        udp_len_d = {udp_len_q[7:0], gmii_rxd};
                    end
                    if (cnt_q == UDP_HEAD_LEN - 5'd1) begin
                        // Length is complete since byte 5; decide on the last header byte.
                        if (udp_len_q < 16'd8) begin
                            bad = 1'b1;
                        end else if (udp_len_q == 16'd8) begin
                            rec_pkt_done_d = 1'b1;
                            rec_byte_num_d = 16'd0;
                            src_mac_d      = mac_sh_q;
                            src_ip_d       = ip_sh_q;
                            state_d        = StRxEnd;
                        end else begin
                            data_num_d = udp_len_q - 16'd8;
                            data_cnt_d = 16'd0;
                            state_d    = StRxData;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            StRxData: begin
                if (gmii_rx_dv) begin
                    // Place byte at its lane; lane 0 starts a fresh word.
                    word_d     = ((pos == 2'd0) ? 32'h0 : word_q)
                                 | ({24'h0, gmii_rxd} << {~pos, 3'b000});
                    data_cnt_d = data_cnt_q + 16'd1;
                    if (pos == 2'd3 || data_cnt_d == data_num_q) begin
                        rec_en_d   = 1'b1;
                        rec_data_d = word_d;
                    end
                    if (data_cnt_d == data_num_q) begin
                        rec_pkt_done_d = 1'b1;
                        rec_byte_num_d = data_num_q;
                        src_mac_d      = mac_sh_q;
                        src_ip_d       = ip_sh_q;
                        state_d        = StRxEnd;
                    end
                end
            end
            StRxEnd: begin
                if (!gmii_rx_dv) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bad) begin
            rx_err_d = 1'b1;
            state_d  = StRxEnd;
        end
        if (active && !gmii_rx_dv) begin
            rx_err_d = 1'b1;
            state_d  = StIdle;
        end
    end

endmodule

// File: tb/tb_video_trans_eth_udp_rx.sv
// Self-checking bench for video_trans_eth_udp_rx: random and directed frames,
// expected events queued by a frame-level model, popped by an output monitor.
module tb_video_trans_eth_udp_rx;

    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123};
    localparam int KEN = 0, KDONE = 1, KERR = 2;

    logic        clk, rst, gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        rec_en, rec_pkt_done, rx_err;
    logic [31:0] rec_data, src_ip;
    logic [15:0] rec_byte_num;
    logic [47:0] src_mac;

    video_trans_eth_udp_rx #(.BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP)) dut (
        .clk(clk), .rst(rst), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
        .rec_en(rec_en), .rec_data(rec_data), .rec_pkt_done(rec_pkt_done),
        .rec_byte_num(rec_byte_num), .src_mac(src_mac), .src_ip(src_ip), .rx_err(rx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [15:0] num;
        logic [47:0] mac;
        logic [31:0] ip;
        bit          with_en;
    } ev_t;

    typedef struct {
        logic [47:0] dst_mac, src_mac;
        logic [15:0] etype;
        logic [7:0]  ver_ihl, proto;
        logic [31:0] src_ip, dst_ip;
        logic [15:0] udp_len;
        int          pad;
        int          trunc;  // payload bytes sent before dv drops, -1 = whole frame
    } frm_t;

    ev_t         exp_q[$];
    logic [7:0]  pay[$];
    logic [7:0]  fb[$];
    logic [47:0] last_mac;
    logic [31:0] last_ip;
    int          checks, errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input logic [31:0] data, input logic [15:0] num,
                           input bit with_en);
        ev_t e;
        e.kind = kind; e.data = data; e.num = num;
        e.mac = last_mac; e.ip = last_ip; e.with_en = with_en;
        exp_q.push_back(e);
    endtask

    // Payload bytes i..i+3 packed MSB first, zero beyond n.
    function automatic logic [31:0] word_at(input int i, input int n);
        logic [31:0] w;
        w = 32'h0;
        for (int j = 0; j < 4; j++)
            if (i + j < n) w = w | ({24'h0, pay[i+j]} << (24 - 8 * j));
        return w;
    endfunction

    task automatic expect_event(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 64'(kind), 64'(e.kind));
            if (e.kind == kind) begin
                if (kind == KEN) chk("rec_data", 64'(rec_data), 64'(e.data));
                if (kind == KDONE) begin
                    chk("rec_byte_num", 64'(rec_byte_num), 64'(e.num));
                    chk("done_with_rec_en", 64'(rec_en), 64'(e.with_en));
                end
                if (kind != KEN) begin
                    chk("src_mac", 64'(src_mac), 64'(e.mac));
                    chk("src_ip", 64'(src_ip), 64'(e.ip));
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rec_en) expect_event(KEN);
            if (rec_pkt_done) expect_event(KDONE);
            if (rx_err) expect_event(KERR);
        end
    end

    task automatic gen_payload(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    task automatic good_frame(output frm_t f, input bit bcast, input int n);
        f.dst_mac = bcast ? 48'hffff_ffff_ffff : BOARD_MAC;
        f.src_mac = {$urandom, $urandom} & 48'hfeff_ffff_ffff;
        f.etype   = 16'h0800;
        f.ver_ihl = 8'h45;
        f.proto   = 8'd17;
        f.src_ip  = $urandom;
        f.dst_ip  = BOARD_IP;
        f.udp_len = 16'(n + 8);
        f.pad     = $urandom_range(0, 3);
        f.trunc   = -1;
        gen_payload(n);
    endtask

    // Frame-level model: what the receiver must report for this frame.
    task automatic model_frame(input frm_t f);
        int  dn;
        bit  ok;
        dn = int'(f.udp_len) - 8;
        ok = (f.dst_mac == BOARD_MAC || f.dst_mac == 48'hffff_ffff_ffff) &&
             f.etype == 16'h0800 && f.ver_ihl == 8'h45 && f.proto == 8'd17 &&
             f.dst_ip == BOARD_IP && f.udp_len >= 16'd8;
        if (!ok) begin
            push_ev(KERR, 32'h0, 16'h0, 1'b0);
        end else if (f.trunc >= 0) begin
            for (int i = 0; i + 4 <= f.trunc; i += 4) push_ev(KEN, word_at(i, dn), 16'h0, 1'b0);
            push_ev(KERR, 32'h0, 16'h0, 1'b0);
        end else begin
            for (int i = 0; i < dn; i += 4) push_ev(KEN, word_at(i, dn), 16'h0, 1'b0);
            last_mac = f.src_mac;
            last_ip  = f.src_ip;
            push_ev(KDONE, 32'h0, 16'(dn), dn > 0);
        end
    endtask

    task automatic push16(input logic [15:0] v);
        fb.push_back(v[15:8]);
        fb.push_back(v[7:0]);
    endtask

    task automatic build_bytes(input frm_t f);
        logic [15:0] tl;
        fb.delete();
        repeat (7) fb.push_back(8'h55);
        fb.push_back(8'hd5);
        for (int i = 5; i >= 0; i--) fb.push_back(f.dst_mac[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) fb.push_back(f.src_mac[i*8 +: 8]);
        push16(f.etype);
        tl = 16'd20 + f.udp_len;
        fb.push_back(f.ver_ihl); fb.push_back(8'h00); push16(tl);
        push16(16'($urandom)); push16(16'h4000);
        fb.push_back(8'h40); fb.push_back(f.proto); push16(16'($urandom));
        for (int i = 3; i >= 0; i--) fb.push_back(f.src_ip[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) fb.push_back(f.dst_ip[i*8 +: 8]);
        push16(16'd1234); push16(16'd5678); push16(f.udp_len); push16(16'h0000);
        foreach (pay[i]) fb.push_back(pay[i]);
        for (int i = 0; i < f.pad + 4; i++) fb.push_back(8'($urandom));
        if (f.trunc >= 0) while (fb.size() > 50 + f.trunc) void'(fb.pop_back());
    endtask

    task automatic send_bytes(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            gmii_rx_dv = 1'b1;
            gmii_rxd   = fb[i];
        end
    endtask

    task automatic run_frame(input frm_t f);
        model_frame(f);
        build_bytes(f);
        send_bytes(fb.size());
        @(negedge clk);
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rec_en"}, 64'(rec_en), 64'h0);
        chk({tag, "_rec_data"}, 64'(rec_data), 64'h0);
        chk({tag, "_rec_pkt_done"}, 64'(rec_pkt_done), 64'h0);
        chk({tag, "_rec_byte_num"}, 64'(rec_byte_num), 64'h0);
        chk({tag, "_src_mac"}, 64'(src_mac), 64'h0);
        chk({tag, "_src_ip"}, 64'(src_ip), 64'h0);
        chk({tag, "_rx_err"}, 64'(rx_err), 64'h0);
    endtask

    initial begin
        frm_t f;
        int   kind, n, guard;
        checks = 0; errors = 0;
        last_mac = '0; last_ip = '0;
        rst = 1'b1; gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Unicast, payload 01..0a.
        good_frame(f, 1'b0, 10);
        for (int i = 0; i < 10; i++) pay[i] = 8'(i + 1);
        f.src_mac = 48'h02_aa_bb_cc_dd_ee; f.src_ip = {8'd192, 8'd168, 8'd1, 8'd10};
        run_frame(f);
        chk("unicast_src_mac", 64'(src_mac), 64'h02aa_bbcc_ddee);

        // Broadcast, deadbeef plus padding.
        good_frame(f, 1'b1, 4);
        pay[0] = 8'hde; pay[1] = 8'had; pay[2] = 8'hbe; pay[3] = 8'hef;
        f.pad = 14;
        run_frame(f);
        chk("bcast_rec_data", 64'(rec_data), 64'hdead_beef);

        // Wrong IP, TCP, ARP, then a clean frame.
        good_frame(f, 1'b0, 6); f.dst_ip = {8'd192, 8'd168, 8'd1, 8'd124}; run_frame(f);
        good_frame(f, 1'b0, 6); f.proto = 8'd6; run_frame(f);
        good_frame(f, 1'b0, 6); f.etype = 16'h0806; run_frame(f);
        good_frame(f, 1'b0, 7); run_frame(f);

        // Truncated after payload byte 5, then clean.
        good_frame(f, 1'b0, 10); f.trunc = 5; run_frame(f);
        good_frame(f, 1'b1, 9); run_frame(f);

        // Zero payload and short UDP length.
        good_frame(f, 1'b0, 0); f.pad = 10; run_frame(f);
        good_frame(f, 1'b0, 0); f.udp_len = 16'd5; f.pad = 10; run_frame(f);

        // Reset mid-payload: only the first word is seen, then everything clears.
        good_frame(f, 1'b0, 10);
        push_ev(KEN, word_at(0, 10), 16'h0, 1'b0);
        build_bytes(f);
        send_bytes(50 + 6);
        @(negedge clk);
        rst = 1'b1; gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        check_outputs_zero("midreset");
        last_mac = '0; last_ip = '0;
        repeat (12) @(negedge clk);
        good_frame(f, 1'b0, 13); run_frame(f);

        // Random mix of valid and faulty frames.
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 8);
            n = $urandom_range(2, 30);
            good_frame(f, kind == 1, n);
            case (kind)
                2: f.dst_ip  = BOARD_IP ^ (32'h1 << $urandom_range(0, 31));
                3: f.proto   = 8'd6;
                4: f.etype   = 16'h0806;
                5: f.dst_mac = {8'hff, BOARD_MAC[39:0]};
                6: begin f.udp_len = 16'($urandom_range(0, 7)); pay.delete(); f.pad = 10; end
                7: f.trunc   = $urandom_range(0, n - 1);
                8: f.ver_ihl = 8'h46;
                default: ;
            endcase
            run_frame(f);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("pending_events", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
